// File: rtl/armleocpu_defs.sv
// rtl/armleocpu_defs.sv - shared load/store encodings and access-tag bit positions
package armleocpu_defs;

   localparam logic [2:0] LOAD_BYTE           = 3'b000;
   localparam logic [2:0] LOAD_HALF           = 3'b001;
   localparam logic [2:0] LOAD_WORD           = 3'b010;
   localparam logic [2:0] LOAD_BYTE_UNSIGNED  = 3'b100;
   localparam logic [2:0] LOAD_HALF_UNSIGNED  = 3'b101;

   localparam logic [1:0] STORE_BYTE          = 2'b00;
   localparam logic [1:0] STORE_HALF          = 2'b01;
   localparam logic [1:0] STORE_WORD          = 2'b10;

   localparam int ACCESSTAG_V = 0;
   localparam int ACCESSTAG_R = 1;
   localparam int ACCESSTAG_W = 2;
   localparam int ACCESSTAG_X = 3;
   localparam int ACCESSTAG_U = 4;
   localparam int ACCESSTAG_G = 5;
   localparam int ACCESSTAG_A = 6;
   localparam int ACCESSTAG_D = 7;

   // Bare mode grants every permission.
   localparam logic [7:0] ACCESSTAG_ALL = 8'hFF;

endpackage

// File: rtl/armleocpu_tlb_array.sv
// rtl/armleocpu_tlb_array.sv - direct-mapped TLB storage with one write and one read port
module armleocpu_tlb_array #(
   parameter int ENTRIES_W = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    invalidate,
   input  logic                    write,
   input  logic [ENTRIES_W-1:0]    write_index,
   input  logic [19-ENTRIES_W:0]   write_tag,
   input  logic [21:0]             write_phys,
   input  logic [7:0]              write_accesstag,
   input  logic [ENTRIES_W-1:0]    read_index,
   output logic                    read_valid,
   output logic [19-ENTRIES_W:0]   read_tag,
   output logic [21:0]             read_phys,
   output logic [7:0]              read_accesstag
);

   localparam int ENTRIES = 1 << ENTRIES_W;

   logic [ENTRIES-1:0]   valid;
   logic [19-ENTRIES_W:0] tag_mem [ENTRIES];
   logic [21:0]          phys_mem [ENTRIES];
   logic [7:0]           acc_mem [ENTRIES];

   // Only valid bits are reset; invalidate beats a simultaneous write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= '0;
      end else if (invalidate) begin
         valid <= '0;
      end else if (write) begin
         valid[write_index] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (write && !invalidate) begin
         tag_mem[write_index]  <= write_tag;
         phys_mem[write_index] <= write_phys;
         acc_mem[write_index]  <= write_accesstag;
      end
   end

   assign read_valid     = valid[read_index];
   assign read_tag       = tag_mem[read_index];
   assign read_phys      = phys_mem[read_index];
   assign read_accesstag = acc_mem[read_index];

endmodule

// File: rtl/armleocpu_lsu_frontend.sv
// rtl/armleocpu_lsu_frontend.sv - TLB lookup plus combinational load/store data formatting
module armleocpu_lsu_frontend
   import armleocpu_defs::*;
#(
   parameter int ENTRIES_W = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tlb_enable,
   input  logic [19:0] tlb_vtag,
   input  logic        tlb_resolve,
   input  logic        tlb_invalidate,
   input  logic        tlb_write,
   input  logic [19:0] tlb_vtag_w,
   input  logic [21:0] tlb_phys_w,
   input  logic [7:0]  tlb_accesstag_w,
   output logic        tlb_done,
   output logic        tlb_miss,
   output logic [21:0] tlb_phys_r,
   output logic [7:0]  tlb_accesstag_r,
   input  logic [1:0]  ld_offset,
   input  logic [2:0]  ld_type,
   input  logic [31:0] ld_data_in,
   output logic [31:0] ld_data_out,
   output logic        ld_missaligned,
   output logic        ld_unknowntype,
   input  logic [1:0]  st_offset,
   input  logic [1:0]  st_type,
   input  logic [31:0] st_data_in,
   output logic [31:0] st_data_out,
   output logic [3:0]  st_mask,
   output logic        st_missaligned,
   output logic        st_unknowntype
);

   logic                  rd_valid;
   logic [19-ENTRIES_W:0] rd_tag;
   logic [21:0]           rd_phys;
   logic [7:0]            rd_accesstag;
   logic                  hit;

   armleocpu_tlb_array #(.ENTRIES_W(ENTRIES_W)) u_array (
      .clk             (clk),
      .rst_n           (rst_n),
      .invalidate      (tlb_invalidate),
      .write           (tlb_write),
      .write_index     (tlb_vtag_w[ENTRIES_W-1:0]),
      .write_tag       (tlb_vtag_w[19:ENTRIES_W]),
      .write_phys      (tlb_phys_w),
      .write_accesstag (tlb_accesstag_w),
      .read_index      (tlb_vtag[ENTRIES_W-1:0]),
      .read_valid      (rd_valid),
      .read_tag        (rd_tag),
      .read_phys       (rd_phys),
      .read_accesstag  (rd_accesstag)
   );

   assign hit = rd_valid && (rd_tag == tlb_vtag[19:ENTRIES_W]);

   // Array reads see pre-edge contents, so same-cycle writes only affect later lookups.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tlb_done        <= 1'b0;
         tlb_miss        <= 1'b0;
         tlb_phys_r      <= '0;
         tlb_accesstag_r <= '0;
      end else begin
         tlb_done <= tlb_resolve;
         if (tlb_resolve) begin
            if (!tlb_enable) begin
               tlb_miss        <= 1'b0;
               tlb_phys_r      <= {2'b00, tlb_vtag};
               tlb_accesstag_r <= ACCESSTAG_ALL;
            end else if (hit) begin
               tlb_miss        <= 1'b0;
               tlb_phys_r      <= rd_phys;
               tlb_accesstag_r <= rd_accesstag;
            end else begin
               tlb_miss        <= 1'b1;
               tlb_phys_r      <= '0;
               tlb_accesstag_r <= '0;
            end
         end
      end
   end

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign ld_byte = ld_data_in[{ld_offset, 3'b000} +: 8];
   assign ld_half = ld_offset[1] ? ld_data_in[31:16] : ld_data_in[15:0];

   always_comb begin
      ld_data_out    = '0;
      ld_missaligned = 1'b0;
      ld_unknowntype = 1'b0;
      case (ld_type)
         LOAD_BYTE:          ld_data_out = {{24{ld_byte[7]}}, ld_byte};
         LOAD_BYTE_UNSIGNED: ld_data_out = {24'h0, ld_byte};
         LOAD_HALF, LOAD_HALF_UNSIGNED: begin
            if (ld_offset[0])
               ld_missaligned = 1'b1;
            else if (ld_type == LOAD_HALF)
               ld_data_out = {{16{ld_half[15]}}, ld_half};
            else
               ld_data_out = {16'h0, ld_half};
         end
         LOAD_WORD: begin
            if (ld_offset != 2'b00)
               ld_missaligned = 1'b1;
            else
               ld_data_out = ld_data_in;
         end
         default:            ld_unknowntype = 1'b1;
      endcase
   end

   always_comb begin
      st_data_out    = '0;
      st_mask        = '0;
      st_missaligned = 1'b0;
      st_unknowntype = 1'b0;
      case (st_type)
         STORE_BYTE: begin
            st_data_out = {24'h0, st_data_in[7:0]} << {st_offset, 3'b000};
            st_mask     = 4'b0001 << st_offset;
         end
         STORE_HALF: begin
            if (st_offset[0]) begin
               st_missaligned = 1'b1;
            end else begin
               st_data_out = st_offset[1] ? {st_data_in[15:0], 16'h0} : {16'h0, st_data_in[15:0]};
               st_mask     = st_offset[1] ? 4'b1100 : 4'b0011;
            end
         end
         STORE_WORD: begin
            if (st_offset != 2'b00) begin
               st_missaligned = 1'b1;
            end else begin
               st_data_out = st_data_in;
               st_mask     = 4'b1111;
            end
         end
         default:    st_unknowntype = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_armleocpu_lsu_frontend.sv
// tb/tb_armleocpu_lsu_frontend.sv - self-checking bench with a behavioural TLB/load/store model
module tb_armleocpu_lsu_frontend;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        tlb_enable, tlb_resolve, tlb_invalidate, tlb_write;
   logic [19:0] tlb_vtag, tlb_vtag_w;
   logic [21:0] tlb_phys_w;
   logic [7:0]  tlb_accesstag_w;
   logic        tlb_done, tlb_miss;
   logic [21:0] tlb_phys_r;
   logic [7:0]  tlb_accesstag_r;
   logic [1:0]  ld_offset;
   logic [2:0]  ld_type;
   logic [31:0] ld_data_in, ld_data_out;
   logic        ld_missaligned, ld_unknowntype;
   logic [1:0]  st_offset, st_type;
   logic [31:0] st_data_in, st_data_out;
   logic [3:0]  st_mask;
   logic        st_missaligned, st_unknowntype;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   armleocpu_lsu_frontend dut (
      .clk(clk), .rst_n(rst_n),
      .tlb_enable(tlb_enable), .tlb_vtag(tlb_vtag), .tlb_resolve(tlb_resolve),
      .tlb_invalidate(tlb_invalidate), .tlb_write(tlb_write), .tlb_vtag_w(tlb_vtag_w),
      .tlb_phys_w(tlb_phys_w), .tlb_accesstag_w(tlb_accesstag_w),
      .tlb_done(tlb_done), .tlb_miss(tlb_miss), .tlb_phys_r(tlb_phys_r),
      .tlb_accesstag_r(tlb_accesstag_r),
      .ld_offset(ld_offset), .ld_type(ld_type), .ld_data_in(ld_data_in),
      .ld_data_out(ld_data_out), .ld_missaligned(ld_missaligned), .ld_unknowntype(ld_unknowntype),
      .st_offset(st_offset), .st_type(st_type), .st_data_in(st_data_in),
      .st_data_out(st_data_out), .st_mask(st_mask), .st_missaligned(st_missaligned),
      .st_unknowntype(st_unknowntype)
   );

   // Model: per-slot full virtual tag, compared whole rather than split into index/tag.
   bit          m_valid [16];
   logic [19:0] m_vtag  [16];
   logic [21:0] m_phys  [16];
   logic [7:0]  m_acc   [16];
   logic        e_done, e_miss;
   logic [21:0] e_phys;
   logic [7:0]  e_acc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_valid[i] = 0;
      e_done = 0; e_miss = 0; e_phys = 0; e_acc = 0;
   endtask

   task automatic model_step();
      int slot;
      e_done = tlb_resolve;
      if (tlb_resolve) begin
         slot = int'(tlb_vtag) % 16;
         if (!tlb_enable) begin
            e_miss = 0; e_phys = 22'(tlb_vtag); e_acc = 8'hFF;
         end else if (m_valid[slot] && m_vtag[slot] == tlb_vtag) begin
            e_miss = 0; e_phys = m_phys[slot]; e_acc = m_acc[slot];
         end else begin
            e_miss = 1; e_phys = 0; e_acc = 0;
         end
      end
      if (tlb_invalidate) begin
         for (int i = 0; i < 16; i++) m_valid[i] = 0;
      end else if (tlb_write) begin
         slot = int'(tlb_vtag_w) % 16;
         m_valid[slot] = 1; m_vtag[slot] = tlb_vtag_w;
         m_phys[slot] = tlb_phys_w; m_acc[slot] = tlb_accesstag_w;
      end
   endtask

   function automatic void ld_model(input logic [2:0] t, input logic [1:0] off, input logic [31:0] d,
                                    output logic [31:0] o, output logic mis, output logic unk);
      int size; bit sgn; longint v, m;
      unk = 0; size = 4; sgn = 0;
      case (t)
         3'd0: begin size = 1; sgn = 1; end
         3'd1: begin size = 2; sgn = 1; end
         3'd2: size = 4;
         3'd4: size = 1;
         3'd5: size = 2;
         default: unk = 1;
      endcase
      mis = !unk && (int'(off) % size != 0);
      if (unk || mis) begin
         o = 0;
      end else begin
         m = (longint'(1) << (8 * size)) - 1;
         v = (longint'(d) >> (8 * int'(off))) & m;
         if (sgn && v >= (m + 1) / 2) v = v - (m + 1);
         o = 32'(v);
      end
   endfunction

   function automatic void st_model(input logic [1:0] t, input logic [1:0] off, input logic [31:0] d,
                                    output logic [31:0] o, output logic [3:0] mk, output logic mis, output logic unk);
      int size;
      unk = (t == 2'd3);
      size = (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : 4;
      mis = !unk && (int'(off) % size != 0);
      if (unk || mis) begin
         o = 0; mk = 0;
      end else begin
         o  = 32'((longint'(d) & ((longint'(1) << (8 * size)) - 1)) << (8 * int'(off)));
         mk = 4'(((1 << size) - 1) << int'(off));
      end
   endfunction

   always @(negedge clk) begin
      logic [31:0] lo, so; logic lm, lu, sm, su; logic [3:0] mk;
      check("tlb_done", 32'(tlb_done), 32'(e_done));
      check("tlb_miss", 32'(tlb_miss), 32'(e_miss));
      check("tlb_phys_r", 32'(tlb_phys_r), 32'(e_phys));
      check("tlb_accesstag_r", 32'(tlb_accesstag_r), 32'(e_acc));
      ld_model(ld_type, ld_offset, ld_data_in, lo, lm, lu);
      check("ld_data_out", ld_data_out, lo);
      check("ld_flags", {30'h0, ld_missaligned, ld_unknowntype}, {30'h0, lm, lu});
      st_model(st_type, st_offset, st_data_in, so, mk, sm, su);
      check("st_data_out", st_data_out, so);
      check("st_mask_flags", {26'h0, st_mask, st_missaligned, st_unknowntype}, {26'h0, mk, sm, su});
   end

   task automatic cycle();
      @(posedge clk);
      if (rst_n) model_step();
      #1;
   endtask

   task automatic idle();
      tlb_resolve = 0; tlb_write = 0; tlb_invalidate = 0;
   endtask

   task automatic resolve(input logic en, input logic [19:0] v);
      idle(); tlb_enable = en; tlb_vtag = v; tlb_resolve = 1; cycle(); idle();
   endtask

   task automatic write(input logic [19:0] v, input logic [21:0] p, input logic [7:0] a);
      idle(); tlb_write = 1; tlb_vtag_w = v; tlb_phys_w = p; tlb_accesstag_w = a; cycle(); idle();
   endtask

   initial begin
      rst_n = 0; model_reset(); idle();
      tlb_enable = 1; tlb_vtag = 0; tlb_vtag_w = 0; tlb_phys_w = 0; tlb_accesstag_w = 0;
      ld_offset = 0; ld_type = 0; ld_data_in = 0; st_offset = 0; st_type = 0; st_data_in = 0;
      cycle(); cycle();
      rst_n = 1;
      check("reset_done", 32'(tlb_done), 32'h0);
      check("reset_phys", 32'(tlb_phys_r), 32'h0);

      resolve(1, 20'h12345);
      check("t1_done", 32'(tlb_done), 32'h1);
      check("t1_miss", 32'(tlb_miss), 32'h1);
      check("t1_phys", 32'(tlb_phys_r), 32'h0);
      cycle();
      check("t1_done_pulse", 32'(tlb_done), 32'h0);
      check("t1_miss_hold", 32'(tlb_miss), 32'h1);

      write(20'h12345, 22'h3ABCD, 8'hCF);
      resolve(1, 20'h12345);
      check("t2_miss", 32'(tlb_miss), 32'h0);
      check("t2_phys", 32'(tlb_phys_r), 32'h3ABCD);
      check("t2_acc", 32'(tlb_accesstag_r), 32'hCF);
      resolve(1, 20'h22345);
      check("t2_alias_miss", 32'(tlb_miss), 32'h1);

      // write and resolve together, then back-to-back resolves
      tlb_write = 1; tlb_vtag_w = 20'h45677; tlb_phys_w = 22'h11111; tlb_accesstag_w = 8'h0F;
      tlb_resolve = 1; tlb_vtag = 20'h45677; cycle();
      check("t3_same_cycle_miss", 32'(tlb_miss), 32'h1);
      tlb_write = 0; cycle();
      check("t3_hit_after", 32'(tlb_phys_r), 32'h11111);
      tlb_vtag = 20'h12345; cycle(); idle();
      check("t3_pipelined_hit", 32'(tlb_phys_r), 32'h3ABCD);

      tlb_invalidate = 1; tlb_resolve = 1; tlb_vtag = 20'h45677; cycle(); idle();
      check("t3_inv_same_cycle_hit", 32'(tlb_miss), 32'h0);
      resolve(1, 20'h45677);
      check("t3_inv_miss", 32'(tlb_miss), 32'h1);

      tlb_invalidate = 1; tlb_write = 1; tlb_vtag_w = 20'h0000A; tlb_phys_w = 22'h2; cycle(); idle();
      resolve(1, 20'h0000A);
      check("t3_inv_beats_write", 32'(tlb_miss), 32'h1);

      write(20'h12345, 22'h00001, 8'h01);
      write(20'h12345, 22'h00002, 8'h03);
      resolve(1, 20'h12345);
      check("overwrite_phys", 32'(tlb_phys_r), 32'h2);
      write(20'h22345, 22'h00033, 8'h07);
      resolve(1, 20'h12345);
      check("evicted_miss", 32'(tlb_miss), 32'h1);

      resolve(0, 20'h80001);
      check("bare_miss", 32'(tlb_miss), 32'h0);
      check("bare_phys", 32'(tlb_phys_r), 32'h080001);
      check("bare_acc", 32'(tlb_accesstag_r), 32'hFF);
      cycle(); cycle();

      ld_data_in = 32'h8899AABB;
      ld_type = 3'b000; ld_offset = 1; #1 check("lb_off1", ld_data_out, 32'hFFFFFFAA);
      ld_type = 3'b100; ld_offset = 3; #1 check("lbu_off3", ld_data_out, 32'h00000088);
      ld_type = 3'b001; ld_offset = 2; #1 check("lh_off2", ld_data_out, 32'hFFFF8899);
      ld_type = 3'b101; ld_offset = 0; #1 check("lhu_off0", ld_data_out, 32'h0000AABB);
      ld_type = 3'b101; ld_offset = 1; #1 check("lhu_mis", {ld_data_out[30:0], ld_missaligned}, 32'h1);
      ld_type = 3'b011; ld_offset = 1; #1 check("ld_unk", {30'h0, ld_missaligned, ld_unknowntype}, 32'h1);
      cycle();
      ld_type = 3'b010; ld_offset = 0; cycle();
      ld_offset = 2; cycle();
      ld_type = 3'b111; cycle();

      st_data_in = 32'hDEADBEA5; st_type = 2'b00; st_offset = 2;
      #1 check("sb_off2", {st_data_out[27:0], st_mask}, {28'h0A50000, 4'b0100});
      st_data_in = 32'hCAFE1234; st_type = 2'b01; st_offset = 2;
      #1 check("sh_off2", {st_data_out[27:0], st_mask}, {28'h2340000, 4'b1100});
      check("sh_off2_hi", st_data_out, 32'h12340000);
      st_type = 2'b10; st_offset = 1;
      #1 check("sw_mis", {st_mask, st_missaligned, st_data_out[26:0]}, {4'b0000, 1'b1, 27'h0});
      st_type = 2'b11; st_offset = 0;
      #1 check("st_unk", {30'h0, st_missaligned, st_unknowntype}, 32'h1);
      cycle();
      st_type = 2'b00; st_offset = 3; cycle();
      st_type = 2'b01; st_offset = 0; cycle();
      st_type = 2'b10; st_offset = 0; cycle();

      write(20'h0ABCD, 22'h00005, 8'h03);
      resolve(1, 20'h0ABCD);
      check("rst_pre_done", 32'(tlb_done), 32'h1);
      check("rst_pre_hit", 32'(tlb_phys_r), 32'h5);
      #2 rst_n = 0; model_reset();
      #1 check("rst_async_done", 32'(tlb_done), 32'h0);
      check("rst_async_phys", 32'(tlb_phys_r), 32'h0);
      tlb_resolve = 1; tlb_vtag = 20'h0ABCD; cycle(); idle();
      check("rst_no_done", 32'(tlb_done), 32'h0);
      cycle();
      rst_n = 1;
      resolve(1, 20'h0ABCD);
      check("rst_cleared_miss", 32'(tlb_miss), 32'h1);
      cycle(); cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/armleocpu_lsu_frontend.md
# armleocpu_lsu_frontend

Address-translation and data-formatting front end for the ArmleoCPU data and fetch cache. It contains three parts:
- a direct-mapped TLB that maps a 20-bit virtual page tag to a 22-bit physical page tag plus an 8-bit access tag;
- a combinational load-data generator (extract and extend);
- a combinational store-data generator (align and byte mask).

The block sits between the cache control FSM and its way storage.

## Interface
- ENTRIES_W, default 4: log2 of TLB entry count (16 entries); legal range 1..8.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- tlb_enable  in  1  satp.mode; 0 = bare (identity) translation.
- tlb_vtag  in  20  virtual page tag to resolve (address[31:12]).
- tlb_resolve  in  1  start a lookup this cycle.
- tlb_invalidate  in  1  invalidate all entries.
- tlb_write  in  1  write one entry.
- tlb_vtag_w  in  20  virtual tag of the entry being written.
- tlb_phys_w  in  22  physical tag to store.
- tlb_accesstag_w  in  8  PTE bits [7:0] (D A G U X W R V) to store.
- tlb_done  out  1  lookup result valid.
- tlb_miss  out  1  lookup missed (qualified by tlb_done).
- tlb_phys_r  out  22  translated physical tag.
- tlb_accesstag_r  out  8  access tag of the hit entry.
- ld_offset  in  2  byte offset within word.
- ld_type  in  3  LB=000, LH=001, LW=010, LBU=100, LHU=101.
- ld_data_in  in  32  raw memory word.
- ld_data_out  out  32  formatted load result.
- ld_missaligned  out  1  misaligned load.
- ld_unknowntype  out  1  illegal load type.
- st_offset  in  2  byte offset within word.
- st_type  in  2  SB=00, SH=01, SW=10.
- st_data_in  in  32  register data to store.
- st_data_out  out  32  data shifted into byte lanes.
- st_mask  out  4  byte-enable mask.
- st_missaligned  out  1  misaligned store.
- st_unknowntype  out  1  illegal store type.

## Operation
TLB entries:
- Each entry holds valid, tag = vtag[19:ENTRIES_W], phys[21:0] and accesstag[7:0].
- Index = vtag[ENTRIES_W-1:0].

Resolve:
- When tlb_enable=1, the result is a hit if the indexed entry is valid and its stored tag equals vtag[19:ENTRIES_W]. On a hit, output the stored phys and accesstag with miss=0.
- On a miss, miss=1 and phys_r/accesstag_r are 0.
- When tlb_enable=0 there is never a miss: phys_r={2'b00, tlb_vtag} and accesstag_r=8'hFF.

Write: sets the indexed entry to valid, with the new tag, phys and accesstag.

Invalidate: clears every valid bit. Entry data is kept.

Load generator (combinational):
- LB/LBU select byte ld_offset.
- LH/LHU select halfword ld_offset[1].
- LW passes the word through.
- LB and LH sign-extend; LBU and LHU zero-extend.
- Misaligned: a halfword load with ld_offset[0]=1, or LW with ld_offset≠0.
- Unknown: types 011, 110 and 111. ld_missaligned is 0 for unknown types.
- ld_data_out = 0 whenever either error flag is set.

Store generator (combinational):
- SB: data_out = data_in[7:0] << (8*offset); mask = 1<<offset.
- SH: data_out = data_in[15:0] << (16*offset[1]); mask = 0011 or 1100.
- SW: data_out = data_in; mask = 1111.
- Misaligned: SH with offset[0]=1, or SW with offset≠0.
- Unknown: type 11.
- On any error, mask = 0000 and data_out = 0.

## Timing
- Resolve latency is one cycle: tlb_done=1 exactly in the cycle after tlb_resolve=1. tlb_enable and tlb_vtag are sampled with tlb_resolve.
- A lookup may be issued every cycle (fully pipelined).
- tlb_miss, tlb_phys_r and tlb_accesstag_r are registered and hold their values until the next resolve.
- tlb_done is a single-cycle pulse per resolve.
- A lookup reads the pre-edge state. A write or invalidate in the same cycle as a resolve affects only later resolves, even for the same vtag.
- Invalidate and write in the same cycle: invalidate wins and the write is dropped.
- Two writes to one index overwrite the entry; there is no replacement policy.
- Reset values (asynchronous): all valid=0; tlb_done=0; tlb_miss=0; tlb_phys_r=0; tlb_accesstag_r=0.
- Reset mid-lookup: the pending done is cancelled.
- Load and store generators have zero latency and no state.

## Structure
- The shared package armleocpu_defs holds the LOAD_* and STORE_* type encodings and the access-tag bit positions.
- The TLB entry array with lookup is the natural single sub-module: armleocpu_tlb_array. Load and store formatting stay inline as combinational logic.

## Test plan
1. Reset, then resolve vtag 0x12345 with enable=1 → next cycle done=1, miss=1, phys_r=0.
2. Write vtag 0x12345, phys 0x3ABCD, acc 0xCF; then resolve 0x12345 → miss=0, phys_r=0x3ABCD, acc=0xCF. Then resolve 0x22345 (same index, other tag) → miss=1.
3. Write and resolve the same vtag in the same cycle → miss=1; resolve again → hit. Invalidate, then resolve → miss=1. With enable=0, resolve 0x80001 → miss=0, phys_r=0x080001, acc=0xFF.
4. ld_data_in=0x8899AABB:
   - LB offset 1 → 0xFFFFFFAA.
   - LBU offset 3 → 0x00000088.
   - LH offset 2 → 0xFFFF8899.
   - LHU offset 1 → missaligned=1, data 0.
   - type 011 → unknowntype=1.
5. Store:
   - SB data 0xA5, offset 2 → 0x00A50000, mask 0100.
   - SH data 0x1234, offset 2 → 0x12340000, mask 1100.
   - SW offset 1 → missaligned=1, mask 0000.
   - type 11 → unknowntype=1.
6. Write an entry, assert rst_n low asynchronously in the middle of a resolve → done=0 immediately; after release, resolving that vtag gives miss=1.
